// File: rtl/even_parity_frame_rx.sv
// Serial even-parity frame receiver: deserializes DATA_W data bits plus one parity
// bit, registers the data and parity verdict, and keeps a saturating error count.
module even_parity_frame_rx #(
  parameter int DATA_W = 3,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_valid,
  input  logic              s_bit,
  input  logic              sof,
  input  logic              clr_cnt,
  output logic              frame_valid,
  output logic [DATA_W-1:0] data_out,
  output logic              parity_bit,
  output logic              parity_err,
  output logic              abort,
  output logic              busy,
  output logic [CNT_W-1:0]  err_count
);

  localparam int BCW = $clog2(DATA_W + 2);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state, state_nx;
  logic [DATA_W-1:0] shreg_p0;
  logic [BCW-1:0]    bit_cnt_p0;
  logic              run_par_p0;

  logic              take_first;
  logic              take_next;
  logic              last_bit;
  logic              frame_err;
  logic [DATA_W-1:0] shreg_nx;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // A sof bit always starts a frame, whether from IDLE or over a partial one.
  assign take_first = bit_valid && sof;
  assign take_next  = bit_valid && !sof && (state == SHIFT);
  assign last_bit   = take_next && (bit_cnt_p0 == BCW'(DATA_W));
  assign frame_err  = run_par_p0 ^ s_bit;
  assign shreg_nx   = DATA_W'({shreg_p0, s_bit});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (take_first) state_nx = SHIFT;
      SHIFT:   if (last_bit)   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == SHIFT);
  end

  // Stage p0: shift register, bit count and running parity.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_p0   <= '0;
      bit_cnt_p0 <= '0;
      run_par_p0 <= 1'b0;
    end else if (take_first) begin
      shreg_p0   <= DATA_W'(s_bit);
      bit_cnt_p0 <= BCW'(1);
      run_par_p0 <= s_bit;
    end else if (last_bit) begin
      shreg_p0   <= '0;
      bit_cnt_p0 <= '0;
      run_par_p0 <= 1'b0;
    end else if (take_next) begin
      shreg_p0   <= shreg_nx;
      bit_cnt_p0 <= bit_cnt_p0 + BCW'(1);
      run_par_p0 <= frame_err;
    end
  end

  // Stage p1: frame results, registered on the edge that takes the parity bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_valid <= 1'b0;
      abort       <= 1'b0;
      data_out    <= '0;
      parity_bit  <= 1'b0;
      parity_err  <= 1'b0;
      err_count   <= '0;
    end else begin
      frame_valid <= last_bit;
      abort       <= take_first && (state == SHIFT);
      if (last_bit) begin
        data_out   <= shreg_p0;
        parity_bit <= s_bit;
        parity_err <= frame_err;
      end
      if (clr_cnt)                    err_count <= '0;
      else if (last_bit && frame_err) err_count <= sat_inc(err_count);
    end
  end

endmodule

// File: tb/tb_even_parity_frame_rx.sv
// Randomized and directed bench for even_parity_frame_rx against a frame-level
// queue model; one instance with the default counter and one with CNT_W=2.
module tb_even_parity_frame_rx;
  localparam int DW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic bit_valid = 1'b0, s_bit = 1'b0, sof = 1'b0, clr_cnt = 1'b0;

  logic          a_fv, a_pb, a_pe, a_ab, a_busy;
  logic [DW-1:0] a_data;
  logic [7:0]    a_cnt;
  logic          b_fv, b_pb, b_pe, b_ab, b_busy;
  logic [DW-1:0] b_data;
  logic [1:0]    b_cnt;

  even_parity_frame_rx #(.DATA_W(DW), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .bit_valid(bit_valid), .s_bit(s_bit), .sof(sof),
    .clr_cnt(clr_cnt), .frame_valid(a_fv), .data_out(a_data), .parity_bit(a_pb),
    .parity_err(a_pe), .abort(a_ab), .busy(a_busy), .err_count(a_cnt));

  even_parity_frame_rx #(.DATA_W(DW), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .bit_valid(bit_valid), .s_bit(s_bit), .sof(sof),
    .clr_cnt(clr_cnt), .frame_valid(b_fv), .data_out(b_data), .parity_bit(b_pb),
    .parity_err(b_pe), .abort(b_ab), .busy(b_busy), .err_count(b_cnt));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  int fv_seen = 0;
  int fv_last = 0;
  int fv_gap  = 0;

  // Frame-level model: the bits of the frame in progress, plus the last results.
  logic          bits[$];
  logic          e_fv, e_ab, e_pb, e_pe;
  logic [DW-1:0] e_data;
  int            e_cnt8, e_cnt2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cycle, act, req);
    end
  endtask

  task automatic model_reset();
    bits.delete();
    e_fv = 0; e_ab = 0; e_pb = 0; e_pe = 0; e_data = '0; e_cnt8 = 0; e_cnt2 = 0;
  endtask

  task automatic model_update(input logic bv, input logic sf, input logic b, input logic cl);
    logic p;
    e_fv = 0;
    e_ab = 0;
    if (bv && sf) begin
      if (bits.size() > 0) e_ab = 1;
      bits.delete();
      bits.push_back(b);
    end else if (bv && bits.size() > 0) begin
      bits.push_back(b);
      if (bits.size() == DW + 1) begin
        e_data = '0;
        p = 0;
        for (int i = 0; i < DW; i++) e_data = {e_data[DW-2:0], bits[i]};
        for (int i = 0; i <= DW; i++) p = p ^ bits[i];
        e_pb = bits[DW];
        e_pe = p;
        e_fv = 1;
        if (p) begin
          if (e_cnt8 < 255) e_cnt8++;
          if (e_cnt2 < 3) e_cnt2++;
        end
        bits.delete();
      end
    end
    if (cl) begin
      e_cnt8 = 0;
      e_cnt2 = 0;
    end
  endtask

  task automatic compare_all();
    logic e_busy;
    e_busy = (bits.size() > 0);
    chk("a_frame_valid", 32'(a_fv), 32'(e_fv));
    chk("a_abort", 32'(a_ab), 32'(e_ab));
    chk("a_busy", 32'(a_busy), 32'(e_busy));
    chk("a_data_out", 32'(a_data), 32'(e_data));
    chk("a_parity_bit", 32'(a_pb), 32'(e_pb));
    chk("a_parity_err", 32'(a_pe), 32'(e_pe));
    chk("a_err_count", 32'(a_cnt), 32'(e_cnt8));
    chk("b_frame_valid", 32'(b_fv), 32'(e_fv));
    chk("b_abort", 32'(b_ab), 32'(e_ab));
    chk("b_busy", 32'(b_busy), 32'(e_busy));
    chk("b_data_out", 32'(b_data), 32'(e_data));
    chk("b_err_count", 32'(b_cnt), 32'(e_cnt2));
    if (a_fv) begin
      fv_seen++;
      fv_gap  = cycle - fv_last;
      fv_last = cycle;
    end
  endtask

  // Inputs change at the falling edge, are taken at the rising edge, and the
  // outputs are compared at the following falling edge.
  task automatic step(input logic bv, input logic sf, input logic b, input logic cl);
    bit_valid = bv; sof = sf; s_bit = b; clr_cnt = cl;
    @(posedge clk);
    cycle++;
    if (rst) model_reset();
    else     model_update(bv, sf, b, cl);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'b0);
  endtask

  task automatic send_frame(input logic [3:0] w, input logic cl_last);
    for (int i = 3; i >= 0; i--) step(1'b1, (i == 3), w[i], (i == 0) && cl_last);
  endtask

  initial begin
    logic [15:0] odd_tbl;
    int          fv0;
    odd_tbl = 16'h6996;
    model_reset();
    @(negedge clk);
    compare_all();
    step(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // Reset mid-frame, then a fresh frame 0,0,1,1.
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("busy_mid_frame", 32'(a_busy), 32'd1);
    #2 rst = 1'b1;
    model_reset();
    #1 compare_all();
    chk("busy_in_reset", 32'(a_busy), 32'd0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    rst = 1'b0;
    send_frame(4'b0011, 1'b0);
    chk("rst_frame_data", 32'(a_data), 32'h1);
    chk("rst_frame_pb", 32'(a_pb), 32'd1);
    chk("rst_frame_pe", 32'(a_pe), 32'd0);
    chk("model_rst_data", 32'(e_data), 32'h1);

    // Ignored bits in IDLE.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'($urandom_range(1)), 1'b0);
    chk("idle_bits_busy", 32'(a_busy), 32'd0);
    chk("idle_bits_fv", 32'(a_fv), 32'd0);

    // All 16 four-bit codes with random gaps between frames.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    fv0 = fv_seen;
    for (int c = 0; c < 16; c++) begin
      send_frame(4'(c), 1'b0);
      chk("exh_fv", 32'(a_fv), 32'd1);
      chk("exh_parity_err", 32'(a_pe), 32'(odd_tbl[c]));
      idle($urandom_range(3));
    end
    chk("exh_fv_count", 32'(fv_seen - fv0), 32'd16);
    chk("exh_err_count", 32'(a_cnt), 32'd8);
    chk("model_exh_cnt", 32'(e_cnt8), 32'd8);

    // Back-to-back frames: 1,1,1,1 then 0,1,1,1.
    send_frame(4'b1111, 1'b0);
    chk("b2b_first_data", 32'(a_data), 32'h7);
    chk("b2b_first_pe", 32'(a_pe), 32'd0);
    send_frame(4'b0111, 1'b0);
    chk("b2b_gap", 32'(fv_gap), 32'd4);
    chk("b2b_second_data", 32'(a_data), 32'h3);
    chk("b2b_second_pe", 32'(a_pe), 32'd1);

    // Abort: sof,1,0 then sof on 0 followed by 1,1,0, with a stall inside the frame.
    fv0 = fv_seen;
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("abort_pulse", 32'(a_ab), 32'd1);
    chk("abort_keeps_data", 32'(a_data), 32'h3);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    idle(2);
    chk("stall_busy", 32'(a_busy), 32'd1);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("abort_fv_count", 32'(fv_seen - fv0), 32'd1);
    chk("abort_frame_data", 32'(a_data), 32'h3);
    chk("abort_frame_pb", 32'(a_pb), 32'd0);
    chk("abort_frame_pe", 32'(a_pe), 32'd0);

    // Saturation of the 2-bit counter, then a clear that wins over an increment.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      send_frame(4'b0001, 1'b0);
      chk("sat_count", 32'(b_cnt), (k < 3) ? 32'(k + 1) : 32'd3);
    end
    send_frame(4'b0001, 1'b1);
    chk("clr_priority_b", 32'(b_cnt), 32'd0);
    chk("clr_priority_a", 32'(a_cnt), 32'd0);

    // Random streams.
    for (int i = 0; i < 3000; i++)
      step(($urandom_range(3) != 0), ($urandom_range(5) == 0), 1'($urandom_range(1)),
           ($urandom_range(63) == 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
